// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int REG_W           = 4;
    localparam int DEFAULT_TIMEOUT = 255;

    // Instruction word a flushed pipeline register is loaded with.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Per-stage register enables and bubble/flush controls, MSB first.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_exe_en;
        logic exe_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_exe_flush;
    } ctrl_t;

    localparam ctrl_t CTRL_FREEZE = '0;

    // Non-freeze decode: a taken branch kills IF/ID and ID/EXE, which also
    // discards any load-use hazard on the killed ID instruction.
    function automatic ctrl_t run_decode(input logic branch, input logic lu);
        ctrl_t c;
        c = '{pc_en: 1'b1, if_id_en: 1'b1, id_exe_en: 1'b1, exe_mem_en: 1'b1,
              mem_wb_en: 1'b1, if_id_flush: 1'b0, id_exe_flush: 1'b0};
        if (branch) begin
            c.if_id_flush  = 1'b1;
            c.id_exe_flush = 1'b1;
        end else if (lu) begin
            c.pc_en        = 1'b0;
            c.if_id_en     = 1'b0;
            c.id_exe_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard comparator between the ID and EXE stages.
module load_use_detector #(
    parameter int REG_W = pipeline_ctrl_pkg::REG_W
) (
    input  logic [REG_W-1:0] RP_id,
    input  logic [REG_W-1:0] RS_id,
    input  logic             usa_rp_id,
    input  logic             usa_rs_id,
    input  logic [REG_W-1:0] RG_exe,
    input  logic             load_exe,
    input  logic             prohib_exe,
    output logic             lu
);

    logic w_rp_hit;
    logic w_rs_hit;

    // Register 0 is compared like any other register.
    assign w_rp_hit = usa_rp_id && (RP_id == RG_exe);
    assign w_rs_hit = usa_rs_id && (RS_id == RG_exe);
    assign lu       = load_exe && !prohib_exe && (w_rp_hit || w_rs_hit);

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: load-use bubble, memory-wait freeze with timeout,
// two-slot branch flush, and a saturating stall-cycle counter.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W   = pipeline_ctrl_pkg::REG_W,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = pipeline_ctrl_pkg::DEFAULT_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] RP_id,
    input  logic [REG_W-1:0] RS_id,
    input  logic             usa_rp_id,
    input  logic             usa_rs_id,
    input  logic [REG_W-1:0] RG_exe,
    input  logic             load_exe,
    input  logic             prohib_exe,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             branch_taken_exe,
    input  logic             clr_stats,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_exe_en,
    output logic             exe_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mem_timeout_err,
    output logic [CNT_W-1:0] stall_count
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TO_W-1:0]  r_wait_cnt;
    logic [TO_W-1:0]  w_wait_cnt_nxt;
    logic             r_branch_pend;
    logic             w_branch_pend_nxt;
    logic             r_timeout_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_lu;
    logic             w_timeout;
    logic             w_set_err;
    ctrl_t            w_ctrl;
    ctrl_t            w_ctrl_out;

    load_use_detector #(.REG_W(REG_W)) u_lu (
        .RP_id      (RP_id),
        .RS_id      (RS_id),
        .usa_rp_id  (usa_rp_id),
        .usa_rs_id  (usa_rs_id),
        .RG_exe     (RG_exe),
        .load_exe   (load_exe),
        .prohib_exe (prohib_exe),
        .lu         (w_lu)
    );

    assign w_timeout = (r_wait_cnt == TO_W'(TIMEOUT));

    // Next-state and Mealy output decode for the RUN / MEM_WAIT sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        w_state_nxt       = r_state;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_branch_pend_nxt = r_branch_pend;
        w_set_err         = 1'b0;
        w_ctrl            = CTRL_FREEZE;
        case (r_state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    w_state_nxt       = MEM_WAIT;
                    w_wait_cnt_nxt    = TO_W'(1);
                    w_branch_pend_nxt = branch_taken_exe;
                end else begin
                    w_ctrl = run_decode(branch_taken_exe, w_lu);
                end
            end
            MEM_WAIT: begin
                if (mem_ack || w_timeout) begin
                    w_ctrl            = run_decode(branch_taken_exe || r_branch_pend, w_lu);
                    w_state_nxt       = RUN;
                    w_branch_pend_nxt = 1'b0;
                    w_set_err         = !mem_ack;
                end else begin
                    w_wait_cnt_nxt    = r_wait_cnt + TO_W'(1);
                    w_branch_pend_nxt = r_branch_pend || branch_taken_exe;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    // Outputs are forced inactive while reset is held.
    assign w_ctrl_out   = rst_n ? w_ctrl : CTRL_FREEZE;
    assign pc_en        = w_ctrl_out.pc_en;
    assign if_id_en     = w_ctrl_out.if_id_en;
    assign id_exe_en    = w_ctrl_out.id_exe_en;
    assign exe_mem_en   = w_ctrl_out.exe_mem_en;
    assign mem_wb_en    = w_ctrl_out.mem_wb_en;
    assign if_id_flush  = w_ctrl_out.if_id_flush;
    assign id_exe_flush = w_ctrl_out.id_exe_flush;

    // Sequencer state, wait counter and deferred-branch flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_branch_pend <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_branch_pend <= w_branch_pend_nxt;
        end
    end

    // Sticky timeout flag and saturating stall counter; clear wins over update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else if (clr_stats) begin
            r_timeout_err <= 1'b0;
            r_stall_cnt   <= '0;
        end else begin
            if (w_set_err)
                r_timeout_err <= 1'b1;
            if (!w_ctrl.pc_en && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign mem_timeout_err = r_timeout_err;
    assign stall_count     = r_stall_cnt;

endmodule
